// File: rtl/wand_stim_seq.sv
// -----------------------------------------------------------------------------
// wand_stim_seq
// Stimulus sequencer for the wired-AND logic stage. It steps the stage inputs
// A,B,C,D through the patterns 0000..1111 and holds each pattern for H clocks.
// H is max(hold_cycles,1) and is latched at start. On the last hold clock of
// each pattern it samples z_in/q_in and compares both against (A&B)&(C|D).
// It counts the ones seen on each response and keeps a sticky mismatch flag.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   run request, honoured only in IDLE
//   hold_cycles  in   clocks per pattern (0 behaves as 1), latched at start
//   z_in, q_in   in   responses from the downstream combinational stage
//   A,B,C,D      out  stimulus bits 3..0, taken directly from pattern_idx
//   pattern_idx  out  current pattern index
//   busy         out  high during RUN
//   done         out  one-cycle pulse after the final sample
//   z_count      out  number of sampled z_in==1 in the last/current run
//   q_count      out  number of sampled q_in==1 in the last/current run
//   mismatch     out  sticky, set when any sample differs from expected
// -----------------------------------------------------------------------------
module wand_stim_seq #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              z_in,
    input  logic              q_in,
    output logic              A,
    output logic              B,
    output logic              C,
    output logic              D,
    output logic [3:0]        pattern_idx,
    output logic              busy,
    output logic              done,
    output logic [4:0]        z_count,
    output logic [4:0]        q_count,
    output logic              mismatch
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

    // Reference function of the wired-AND stage for a given pattern.
    function automatic logic expected_resp(input logic [3:0] pat);
        return (pat[3] & pat[2]) & (pat[1] | pat[0]);
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        pattern_q, pattern_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_lat_q, hold_lat_d;
    logic [4:0]        z_count_q, z_count_d;
    logic [4:0]        q_count_q, q_count_d;
    logic              mismatch_q, mismatch_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_hold_s;
    logic              exp_s;

    // The hold counter runs 0..H-1. H is never 0, so H-1 cannot wrap.
    assign last_hold_s = (hold_cnt_q == (hold_lat_q - HOLD_ONE));
    assign exp_s       = expected_resp(pattern_q);

    // State register plus the registered datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pattern_q  <= 4'd0;
            hold_cnt_q <= HOLD_ZERO;
            hold_lat_q <= HOLD_ONE;
            z_count_q  <= 5'd0;
            q_count_q  <= 5'd0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            hold_cnt_q <= hold_cnt_d;
            hold_lat_q <= hold_lat_d;
            z_count_q  <= z_count_d;
            q_count_q  <= q_count_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_hold_s && (pattern_q == 4'd15)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: run setup, hold counting, and sampling/scoring.
    always_comb begin
        pattern_d  = pattern_q;
        hold_cnt_d = hold_cnt_q;
        hold_lat_d = hold_lat_q;
        z_count_d  = z_count_q;
        q_count_d  = q_count_q;
        mismatch_d = mismatch_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pattern_d  = 4'd0;
                    hold_cnt_d = HOLD_ZERO;
                    hold_lat_d = (hold_cycles == HOLD_ZERO) ? HOLD_ONE : hold_cycles;
                    z_count_d  = 5'd0;
                    q_count_d  = 5'd0;
                    mismatch_d = 1'b0;
                end else begin
                    pattern_d  = pattern_q;
                end
            end
            S_RUN: begin
                if (last_hold_s) begin
                    z_count_d  = z_count_q + {4'd0, z_in};
                    q_count_d  = q_count_q + {4'd0, q_in};
                    mismatch_d = mismatch_q | (z_in != exp_s) | (q_in != exp_s);
                    hold_cnt_d = HOLD_ZERO;
                    // The final pattern stays on the outputs until the next start.
                    if (pattern_q != 4'd15) begin
                        pattern_d = pattern_q + 4'd1;
                    end else begin
                        pattern_d = pattern_q;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            S_DONE: begin
                pattern_d = pattern_q;
            end
            default: begin
                pattern_d = pattern_q;
            end
        endcase
    end

    // Output decode from the next state, so busy/done are registered and line up with state.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
            S_RUN: begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign pattern_idx = pattern_q;
    assign A           = pattern_q[3];
    assign B           = pattern_q[2];
    assign C           = pattern_q[1];
    assign D           = pattern_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign z_count     = z_count_q;
    assign q_count     = q_count_q;
    assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_wand_stim_seq.sv
// -----------------------------------------------------------------------------
// tb_wand_stim_seq
// Directed bench for wand_stim_seq. A behavioural model of the wired-AND stage
// drives z_in/q_in. Optionally it forces z_in low on pattern 15. Expected
// timings and counts are computed by hand: three patterns (1101,1110,1111)
// give a 1.
// -----------------------------------------------------------------------------
module tb_wand_stim_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] hold_cycles;
    logic       z_in;
    logic       q_in;
    logic       A, B, C, D;
    logic [3:0] pattern_idx;
    logic       busy;
    logic       done;
    logic [4:0] z_count;
    logic [4:0] q_count;
    logic       mismatch;
    logic       fault_en;

    int n_tests = 0;
    int n_fail  = 0;

    wand_stim_seq #(.HOLD_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hold_cycles(hold_cycles),
        .z_in       (z_in),
        .q_in       (q_in),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .pattern_idx(pattern_idx),
        .busy       (busy),
        .done       (done),
        .z_count    (z_count),
        .q_count    (q_count),
        .mismatch   (mismatch)
    );

    // Downstream stage model (combinational), with an optional z fault on pattern 15.
    assign q_in = (A & B) & (C | D);
    assign z_in = (fault_en && (pattern_idx == 4'd15)) ? 1'b0 : ((A & B) & (C | D));

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Launch one run and watch it to completion; checks timing, sequence and results.
    task automatic run_and_watch(input logic [3:0] h, input logic pulse_mid,
                                 input int exp_z, input int exp_q,
                                 input logic exp_mm, input string tag);
        int heff;
        int bc;
        int dc;
        int done_at;
        int perr;
        heff    = (h == 4'd0) ? 1 : int'(h);
        bc      = 0;
        dc      = 0;
        done_at = -1;
        perr    = 0;
        hold_cycles = h;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        hold_cycles = 4'd7;             // must be ignored while running
        for (int i = 0; i < 16 * heff + 4; i++) begin
            if (pulse_mid) start = (i == 5) ? 1'b1 : 1'b0;
            if (busy) begin
                if (pattern_idx != 4'(bc / heff)) perr++;
                bc++;
            end
            if ({A, B, C, D} != pattern_idx) perr++;
            if (done) begin
                dc++;
                if (done_at < 0) done_at = i;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, bc, 16 * heff);
        check({tag, "_done_pulses"}, dc, 1);
        check({tag, "_done_at"}, done_at, 16 * heff);
        check({tag, "_seq_errs"}, perr, 0);
        check({tag, "_z_count"}, {27'd0, z_count}, exp_z);
        check({tag, "_q_count"}, {27'd0, q_count}, exp_q);
        check({tag, "_mismatch"}, {31'd0, mismatch}, {31'd0, exp_mm});
        check({tag, "_final_idx"}, {28'd0, pattern_idx}, 32'd15);
    endtask

    initial begin
        int  dn;
        int  bz;
        logic busy_log [0:39];
        logic done_log [0:39];

        rst         = 1'b1;
        start       = 1'b0;
        hold_cycles = 4'd0;
        fault_en    = 1'b0;
        #12;
        check("rst_idx",  {28'd0, pattern_idx}, 32'd0);
        check("rst_abcd", {28'd0, A, B, C, D}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cnts", {22'd0, z_count, q_count}, 32'd0);
        check("rst_mm",   {31'd0, mismatch}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Nominal, longer hold, zero hold
        run_and_watch(4'd1, 1'b0, 3, 3, 1'b0, "h1");
        run_and_watch(4'd3, 1'b0, 3, 3, 1'b0, "h3");
        run_and_watch(4'd0, 1'b0, 3, 3, 1'b0, "h0");

        // Fault on z for pattern 15, then a clean run clears mismatch
        fault_en = 1'b1;
        run_and_watch(4'd1, 1'b0, 2, 3, 1'b1, "fault");
        fault_en = 1'b0;
        run_and_watch(4'd1, 1'b0, 3, 3, 1'b0, "clear");

        // Start pulse during RUN changes nothing
        run_and_watch(4'd2, 1'b1, 3, 3, 1'b0, "midpulse");

        // Reset mid-run at pattern 7
        hold_cycles = 4'd1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && pattern_idx != 4'd7; i++) @(negedge clk);
        check("mr_reach7", {28'd0, pattern_idx}, 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check("mr_idx",  {28'd0, pattern_idx}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_cnts", {22'd0, z_count, q_count}, 32'd0);
        check("mr_mm",   {31'd0, mismatch}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        bz = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dn++;
            if (busy) bz++;
            @(negedge clk);
        end
        check("mr_no_done", dn, 0);
        check("mr_no_busy", bz, 0);
        run_and_watch(4'd1, 1'b0, 3, 3, 1'b0, "after_rst");

        // start held high: runs repeat with one IDLE cycle between done and busy
        hold_cycles = 4'd1;
        start       = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            busy_log[i] = busy;
            done_log[i] = done;
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_busy0",  {31'd0, busy_log[0]},  32'd1);
        check("b2b_busy15", {31'd0, busy_log[15]}, 32'd1);
        check("b2b_done16", {31'd0, done_log[16]}, 32'd1);
        check("b2b_busy16", {31'd0, busy_log[16]}, 32'd0);
        check("b2b_idle17", {30'd0, busy_log[17], done_log[17]}, 32'd0);
        check("b2b_busy18", {31'd0, busy_log[18]}, 32'd1);
        check("b2b_done34", {31'd0, done_log[34]}, 32'd1);
        for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
        check("b2b_settle", {30'd0, busy, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
